// File: rtl/mux4x2_sel_if.sv
// mux4x2_sel_if: bundles the data/select/enable inputs and the registered result
// of the mux4x2_sel selector.
//
// Signals:
//   en        capture enable (master -> slave)
//   i0..i3    WIDTH-bit data inputs (master -> slave)
//   s1, s0    select pair, s1 = MSB (master -> slave)
//   out       registered selected data (slave -> master)
//   out_valid high for the cycle after a capture (slave -> master)
//
// Modports:
//   master  drives the inputs and observes the result (testbench / upstream logic)
//   slave   the selector itself
interface mux4x2_sel_if #(
    parameter int unsigned WIDTH = 1
);
    logic             en;
    logic [WIDTH-1:0] i0;
    logic [WIDTH-1:0] i1;
    logic [WIDTH-1:0] i2;
    logic [WIDTH-1:0] i3;
    logic             s1;
    logic             s0;
    logic [WIDTH-1:0] out;
    logic             out_valid;

    modport master (
        output en,
        output i0,
        output i1,
        output i2,
        output i3,
        output s1,
        output s0,
        input  out,
        input  out_valid
    );

    modport slave (
        input  en,
        input  i0,
        input  i1,
        input  i2,
        input  i3,
        input  s1,
        input  s0,
        output out,
        output out_valid
    );
endinterface

// File: rtl/mux4x2_sel.sv
// mux4x2_sel: registered 4:1 selector built as a two-level tree of 2:1 multiplexers.
//
// Level 1 (s0): m01 = s0 ? i1 : i0, m23 = s0 ? i3 : i2
// Level 2 (s1): sel = s1 ? m23 : m01
// The selected word is captured into out on a rising clk edge when en=1, with
// out_valid set for the following cycle. With en=0, out holds and out_valid clears.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears out and out_valid immediately
//   bus    mux4x2_sel_if slave modport (en, i0..i3, s1, s0, out, out_valid)

// Reusable WIDTH-wide 2:1 multiplexer: y = s ? b : a.
module mux4x2_sel_mux2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);
    // A known select passes only the chosen operand, so X/Z on the other one
    // cannot leak through.
    assign y = s ? b : a;
endmodule

module mux4x2_sel #(
    parameter int unsigned WIDTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    mux4x2_sel_if.slave  bus
);
    logic [WIDTH-1:0] m01;
    logic [WIDTH-1:0] m23;
    logic [WIDTH-1:0] sel;

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             valid_q;
    logic             valid_d;

    // Level 1: s0 picks within each pair.
    mux4x2_sel_mux2 #(
        .WIDTH (WIDTH)
    ) u_mux_01 (
        .a (bus.i0),
        .b (bus.i1),
        .s (bus.s0),
        .y (m01)
    );

    mux4x2_sel_mux2 #(
        .WIDTH (WIDTH)
    ) u_mux_23 (
        .a (bus.i2),
        .b (bus.i3),
        .s (bus.s0),
        .y (m23)
    );

    // Level 2: s1 picks between the pairs.
    mux4x2_sel_mux2 #(
        .WIDTH (WIDTH)
    ) u_mux_out (
        .a (m01),
        .b (m23),
        .s (bus.s1),
        .y (sel)
    );

    always_comb begin
        out_d   = out_q;
        valid_d = 1'b0;
        if (bus.en) begin
            out_d   = sel;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_mux4x2_sel.sv
// Directed testbench for mux4x2_sel: a WIDTH=1 and a WIDTH=8 instance share clock
// and reset; expected values are hand-computed constants.
module tb_mux4x2_sel;
    logic clk;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    mux4x2_sel_if #(.WIDTH(1)) bus1 ();
    mux4x2_sel_if #(.WIDTH(8)) bus8 ();

    mux4x2_sel #(
        .WIDTH (1)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    mux4x2_sel #(
        .WIDTH (8)
    ) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic exp_out, input logic exp_vld);
        checks++;
        assert (bus1.out === exp_out) else begin
            failures++;
            $error("FAIL %s out: observed=%b expected=%b", tag, bus1.out, exp_out);
        end
        checks++;
        assert (bus1.out_valid === exp_vld) else begin
            failures++;
            $error("FAIL %s out_valid: observed=%b expected=%b", tag, bus1.out_valid,
                   exp_vld);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] exp_out, input logic exp_vld);
        checks++;
        assert (bus8.out === exp_out) else begin
            failures++;
            $error("FAIL %s out8: observed=%h expected=%h", tag, bus8.out, exp_out);
        end
        checks++;
        assert (bus8.out_valid === exp_vld) else begin
            failures++;
            $error("FAIL %s out_valid8: observed=%b expected=%b", tag, bus8.out_valid,
                   exp_vld);
        end
    endtask

    task automatic drv1(input logic [3:0] iv, input logic [1:0] s);
        bus1.i0 = iv[3];
        bus1.i1 = iv[2];
        bus1.i2 = iv[1];
        bus1.i3 = iv[0];
        {bus1.s1, bus1.s0} = s;
    endtask

    initial begin
        logic [3:0] hot;

        // Reset asserted with inputs toggling and en=1.
        rst_n   = 1'b0;
        bus1.en = 1'b1;
        bus8.en = 1'b1;
        drv1(4'b1111, 2'b00);
        bus8.i0 = 8'hA5; bus8.i1 = 8'h3C; bus8.i2 = 8'hFF; bus8.i3 = 8'h00;
        bus8.s1 = 1'b0; bus8.s0 = 1'b0;
        #2;
        chk1("reset_init", 1'b0, 1'b0);
        chk8("reset_init", 8'h00, 1'b0);
        tick();
        drv1(4'b0101, 2'b11);
        tick();
        chk1("reset_held", 1'b0, 1'b0);
        chk8("reset_held", 8'h00, 1'b0);

        // Release with en=0: nothing captured.
        bus1.en = 1'b0;
        bus8.en = 1'b0;
        rst_n   = 1'b1;
        tick();
        chk1("release_en0", 1'b0, 1'b0);
        chk8("release_en0", 8'h00, 1'b0);

        // Select sweep, WIDTH=1. iv = {i0,i1,i2,i3}.
        bus1.en = 1'b1;
        drv1(4'b1011, 2'b10); tick(); chk1("sweep_a", 1'b1, 1'b1);
        drv1(4'b0100, 2'b10); tick(); chk1("sweep_b", 1'b0, 1'b1);
        drv1(4'b0010, 2'b01); tick(); chk1("sweep_c", 1'b0, 1'b1);
        drv1(4'b0001, 2'b11); tick(); chk1("sweep_d", 1'b1, 1'b1);
        drv1(4'b1000, 2'b00); tick(); chk1("sweep_e", 1'b1, 1'b1);

        // One-hot isolation: addressed input alone high, then alone low.
        for (int s = 0; s < 4; s++) begin
            hot = 4'b1000 >> s;
            drv1(hot, 2'(s));
            tick();
            chk1($sformatf("onehot_hi_%0d", s), 1'b1, 1'b1);
            drv1(~hot, 2'(s));
            tick();
            chk1($sformatf("onehot_lo_%0d", s), 1'b0, 1'b1);
        end

        // X on unselected inputs must not reach out.
        bus1.i0 = 1'b1; bus1.i1 = 1'bx; bus1.i2 = 1'bz; bus1.i3 = 1'bx;
        bus1.s1 = 1'b0; bus1.s0 = 1'b0;
        tick();
        chk1("x_unselected", 1'b1, 1'b1);

        // Hold: capture i2=1, then en=0 with changing inputs/select.
        drv1(4'b0010, 2'b10); tick(); chk1("hold_capture", 1'b1, 1'b1);
        bus1.en = 1'b0;
        drv1(4'b0000, 2'b01); tick(); chk1("hold_1", 1'b1, 1'b0);
        drv1(4'b1101, 2'b10); tick(); chk1("hold_2", 1'b1, 1'b0);

        // Select change between edges only; the edge value is what counts.
        bus1.en = 1'b1;
        drv1(4'b0100, 2'b00);
        #2;
        drv1(4'b0100, 2'b01);
        tick();
        chk1("edge_sample", 1'b1, 1'b1);

        // Async reset mid-stream, between edges.
        drv1(4'b0010, 2'b10); tick(); chk1("pre_async", 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("async_reset", 1'b0, 1'b0);
        chk8("async_reset", 8'h00, 1'b0);
        tick();
        chk1("async_reset_held", 1'b0, 1'b0);
        rst_n   = 1'b1;
        bus1.en = 1'b0;

        // WIDTH=8 sweep over sel 00..11.
        bus8.en = 1'b1;
        bus8.s1 = 1'b0; bus8.s0 = 1'b0; tick(); chk8("w8_sel00", 8'hA5, 1'b1);
        bus8.s1 = 1'b0; bus8.s0 = 1'b1; tick(); chk8("w8_sel01", 8'h3C, 1'b1);
        bus8.s1 = 1'b1; bus8.s0 = 1'b0; tick(); chk8("w8_sel10", 8'hFF, 1'b1);
        bus8.s1 = 1'b1; bus8.s0 = 1'b1; tick(); chk8("w8_sel11", 8'h00, 1'b1);
        bus8.en = 1'b0;
        bus8.s1 = 1'b0; bus8.s0 = 1'b1; tick(); chk8("w8_hold", 8'h00, 1'b0);
        chk1("w1_idle", 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mux4x2_sel.md
Name: mux4x2_sel

Overview:
- Registered 4:1 selector built as a two-level tree of 2:1 multiplexers.
- Selects one of four data inputs using the select pair {s1,s0} and presents the result on a registered output one clock later.
- Used as a small datapath steering element wherever a clean, flop-bounded selection point is needed.

Parameters:
- WIDTH, 1, bit width of each data input and of out.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable; when 1, out/out_valid load on the next rising clk edge.
- i0  input  WIDTH  data input, selected when {s1,s0}=00.
- i1  input  WIDTH  data input, selected when {s1,s0}=01.
- i2  input  WIDTH  data input, selected when {s1,s0}=10.
- i3  input  WIDTH  data input, selected when {s1,s0}=11.
- s1  input  1  select MSB; drives the second (output) tree level.
- s0  input  1  select LSB; drives the first tree level.
- out  output  WIDTH  registered selected data.
- out_valid  output  1  high for the cycle(s) after a capture; indicates out holds a selected value.

Behaviour:
- Tree structure, purely combinational in front of the register:
  - Level 1: m01 = s0 ? i1 : i0; m23 = s0 ? i3 : i2.
  - Level 2: sel = s1 ? m23 : m01.
  - The 2:1 element is a reusable WIDTH-wide submodule, instantiated three times.
- Mapping of {s1,s0} to the selected input: 00 -> i0, 01 -> i1, 10 -> i2, 11 -> i3.
- Register stage:
  - On rising clk with en=1: out <= sel and out_valid <= 1.
  - On rising clk with en=0: out holds its value and out_valid <= 0.
- Latency is exactly 1 clock from input/select change (sampled at the edge) to out.
- Reset:
  - While rst_n=0, asynchronously and immediately: out = 0 (all WIDTH bits) and out_valid = 0, independent of clk.
  - Reset has priority over en.
  - Release is synchronous in effect: the first capture occurs on the first rising edge where rst_n=1 and en=1.
  - Reset asserted mid-operation clears both outputs immediately; prior data is lost.
- Select changes between edges have no effect on out; only values present at the edge matter.
- X/Z on an unselected input must not affect out.
- Data is bitwise: each bit of out follows the same select. There is no arithmetic and no width conversion.
- No internal state besides the out and out_valid flops.

Test Plan:
- Reset: rst_n=0 with inputs toggling -> out=0, out_valid=0 immediately and held; release rst_n with en=0 -> out stays 0.
- Select sweep with en=1 and WIDTH=1, each vector held for one edge, checked one cycle later:
  - i0..i3=1,0,1,1, {s1,s0}=10 -> out=1.
  - i=0,1,0,0, sel=10 -> out=0.
  - i=0,0,1,0, sel=01 -> out=0.
  - i=0,0,0,1, sel=11 -> out=1.
  - i=1,0,0,0, sel=00 -> out=1.
  - out_valid=1 after each capture.
- One-hot isolation: for each sel value, drive only the addressed input to 1 and others to 0 -> out=1; then drive only the addressed input to 0 and others to 1 -> out=0.
- Hold: capture i2=1 with sel=10, then en=0 while changing sel and inputs -> out stays 1, out_valid=0 from the next edge.
- Async reset mid-stream: out=1, assert rst_n low between clock edges -> out=0 and out_valid=0 before the next edge.
- WIDTH=8: i0=8'hA5, i1=8'h3C, i2=8'hFF, i3=8'h00, sweep sel 00..11 -> out = A5, 3C, FF, 00 on successive cycles.
